adv7393_pixel_out: RTL

- Reader/consumer end of the ADV7393 line FIFO, in the pixel clock domain.
- Generates the raster timing (HSYNC/VSYNC/BLANK), pops 16-bit pixels from the line buffer's normal-mode FIFO read port during active video, and drives the registered pixel bus to the ADV7393.
- Substitutes a blank colour and flags underrun when the FIFO runs dry mid-line.

---
 rtl/adv7393_pixel_out.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/adv7393_pixel_out.sv
// Pixel-clock reader for the ADV7393 line FIFO: raster timing generator,
// FIFO pop control and a two-stage registered pixel/sync output pipeline.
module adv7393_pixel_out #(
    parameter int unsigned H_ACTIVE    = 720,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 62,
    parameter int unsigned H_BP        = 60,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 9,
    parameter int unsigned V_SYNC      = 6,
    parameter int unsigned V_BP        = 30,
    parameter logic [15:0] BLANK_VALUE = 16'h8010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        read_ready,
    input  logic [15:0] line_fifo_dout,
    input  logic        line_fifo_empty,
    output logic        line_fifo_read,
    output logic [15:0] pixel_data,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        blank_n,
    output logic        frame_start,
    output logic        underrun,
    input  logic        underrun_clear
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state, state_nxt;
    logic [HW-1:0] h_cnt, h_nxt;
    logic [VW-1:0] v_cnt, v_nxt;

    logic running;
    logic active;
    logic hs;
    logic vs;
    logic miss;
    logic first;

    logic active_d1;
    logic hs_d1;
    logic vs_d1;
    logic miss_d1;
    logic first_d1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            state <= state_nxt;
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
        end
    end

    // enable is only honoured at the frame wrap, so a frame always completes
    always_comb begin
        state_nxt = state;
        h_nxt     = h_cnt;
        v_nxt     = v_cnt;
        case (state)
            IDLE: begin
                h_nxt = '0;
                v_nxt = '0;
                if (enable && read_ready) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (h_cnt == H_LAST) begin
                    h_nxt = '0;
                    if (v_cnt == V_LAST) begin
                        v_nxt = '0;
                        if (!enable) begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        v_nxt = v_cnt + 1'b1;
                    end
                end else begin
                    h_nxt = h_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                h_nxt     = '0;
                v_nxt     = '0;
            end
        endcase
    end

    always_comb begin
        running        = (state == RUN);
        active         = running && (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs             = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
        vs             = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
        first          = running && (h_cnt == '0) && (v_cnt == '0);
        line_fifo_read = active && !line_fifo_empty;
        miss           = active && line_fifo_empty;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_d1 <= 1'b0;
            hs_d1     <= 1'b0;
            vs_d1     <= 1'b0;
            miss_d1   <= 1'b0;
            first_d1  <= 1'b0;
        end else begin
            active_d1 <= active;
            hs_d1     <= hs;
            vs_d1     <= vs;
            miss_d1   <= miss;
            first_d1  <= first;
        end
    end

    // FIFO data arrives one clock after the pop, aligned with the stage-1 flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixel_data  <= BLANK_VALUE;
            blank_n     <= 1'b0;
            hsync_n     <= 1'b1;
            vsync_n     <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            pixel_data  <= (active_d1 && !miss_d1) ? line_fifo_dout : BLANK_VALUE;
            blank_n     <= active_d1;
            hsync_n     <= !hs_d1;
            vsync_n     <= !vs_d1;
            frame_start <= first_d1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            underrun <= 1'b0;
        end else if (miss_d1) begin
            underrun <= 1'b1;
        end else if (underrun_clear) begin
            underrun <= 1'b0;
        end
    end

endmodule
